// File: rtl/matdet10_stream.sv
// Serial 10x10 matrix loader around a combinational division-free determinant core.
// Elements stream in row-major order; the result is held on m_valid/m_ready until it is taken.

module matdet10 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH*100-1:0] a_i,
  output logic [DATA_WIDTH-1:0]     det_o
);
  typedef logic [DATA_WIDTH-1:0] elem_t;

  // Bird's iteration: X <- mu(X)*A nine times, det = (-1)^9 * X[0][0]; ring-only ops.
  always_comb begin : p_det
    elem_t a  [10][10];
    elem_t x  [10][10];
    elem_t mu [10][10];
    elem_t acc;
    elem_t tr;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        a[i][j] = a_i[DATA_WIDTH*(i*10+j) +: DATA_WIDTH];
        x[i][j] = a[i][j];
      end
    end
    for (int s = 0; s < 9; s++) begin
      tr = '0;
      for (int i = 9; i >= 0; i--) begin
        for (int j = 0; j < 10; j++) begin
          mu[i][j] = (j > i) ? x[i][j] : '0;
        end
        mu[i][i] = -tr;
        tr = tr + x[i][i];
      end
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < 10; j++) begin
          acc = '0;
          for (int l = 0; l < 10; l++) begin
            acc = acc + mu[i][l] * a[l][j];
          end
          x[i][j] = acc;
        end
      end
    end
    det_o = -x[0][0];
  end
endmodule

module matdet10_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int EVAL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_det,
  output logic                  m_err
);
  localparam int EW = $clog2(EVAL_CYCLES + 1);

  typedef enum logic [1:0] {LOAD, EVAL, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [6:0]                cnt_q, cnt_d;
  logic [EW-1:0]             eval_q, eval_d;
  logic [DATA_WIDTH*100-1:0] mat_q, mat_d;
  logic [DATA_WIDTH-1:0]     det_q, det_d;
  logic                      err_q, err_d;
  logic                      merr_q, merr_d;
  logic                      valid_q, valid_d;
  logic                      rdy_en_q;
  logic [DATA_WIDTH-1:0]     core_det;
  logic                      accept;

  matdet10 #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .a_i   (mat_q),
    .det_o (core_det)
  );

  assign s_ready = rdy_en_q && (state_q == LOAD);
  assign accept  = s_valid && s_ready;
  assign m_valid = valid_q;
  assign m_det   = det_q;
  assign m_err   = merr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval_d  = eval_q;
    mat_d   = mat_q;
    det_d   = det_q;
    err_d   = err_q;
    merr_d  = merr_q;
    valid_d = valid_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          mat_d[DATA_WIDTH*cnt_q +: DATA_WIDTH] = s_data;
          if (cnt_q == 7'd99) begin
            // Eval window counts one extra cycle so capture lands EVAL_CYCLES+1 after the last element.
            state_d = EVAL;
            eval_d  = EW'(EVAL_CYCLES);
            err_d   = !s_last;
          end else if (s_last) begin
            state_d = HOLD;
            err_d   = 1'b1;
            merr_d  = 1'b1;
            det_d   = '0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      EVAL: begin
        if (eval_q == '0) begin
          state_d = HOLD;
          det_d   = core_det;
          merr_d  = err_q;
          valid_d = 1'b1;
        end else begin
          eval_d = eval_q - EW'(1);
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = LOAD;
          valid_d = 1'b0;
          err_d   = 1'b0;
          merr_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      eval_q   <= '0;
      mat_q    <= '0;
      det_q    <= '0;
      err_q    <= 1'b0;
      merr_q   <= 1'b0;
      valid_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      eval_q   <= eval_d;
      mat_q    <= mat_d;
      det_q    <= det_d;
      err_q    <= err_d;
      merr_q   <= merr_d;
      valid_q  <= valid_d;
      rdy_en_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_matdet10_stream.sv
// Directed bench for matdet10_stream: hand-computed determinants, latency, framing, backpressure, reset.
module tb_matdet10_stream;
  localparam int DW = 8;
  localparam int EC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b1;
  logic          s_ready, m_valid, m_err;
  logic [DW-1:0] m_det;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] mat [100];

  always #5 clk = ~clk;

  matdet10_stream #(.DATA_WIDTH(DW), .EVAL_CYCLES(EC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_det   (m_det),
    .m_err   (m_err)
  );

  task automatic fill_diag(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    for (int k = 0; k < 100; k++) mat[k] = '0;
    for (int i = 0; i < 10; i++) mat[i*11] = (i < 5) ? lo : hi;
  endtask

  // Drives n elements from mat; s_last asserted on element last_at (-1 for none).
  task automatic stream(input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      int g;
      g = 0;
      while (!s_ready && g < 300) begin
        @(negedge clk);
        g++;
      end
      if (g >= 300) begin
        n_cmp++; n_err++;
        $display("FAIL stream_ready k=%0d: s_ready=%b required 1", k, s_ready);
        s_valid = 1'b0;
        return;
      end
      s_valid = 1'b1;
      s_data  = mat[k];
      s_last  = (k == last_at);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic collect(output logic [DW-1:0] det, output logic err, output int lat);
    lat = 0;
    while (!m_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    det = m_det;
    err = m_err;
  endtask

  task automatic check_frame(input string name, input logic [DW-1:0] exp_det, input logic exp_err,
                             input int exp_lat);
    logic [DW-1:0] det;
    logic          err;
    int            lat;
    collect(det, err, lat);
    n_cmp++;
    if (lat !== exp_lat) begin
      n_err++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (det !== exp_det) begin
      n_err++; $display("FAIL %s_det: got %h want %h", name, det, exp_det);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_err++; $display("FAIL %s_err: got %b want %b", name, err, exp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_det !== '0 || m_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: s_ready=%b m_valid=%b m_det=%h m_err=%b want 0 0 00 0",
               s_ready, m_valid, m_det, m_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    fill_diag(8'd1, 8'd1);
    stream(100, 99);
    check_frame("identity", 8'h01, 1'b0, EC + 1);
  endtask

  task automatic test_swap();
    fill_diag(8'd1, 8'd1);
    mat[0] = 8'd0; mat[11] = 8'd0; mat[1] = 8'd1; mat[10] = 8'd1;
    stream(100, 99);
    check_frame("swap", 8'hFF, 1'b0, EC + 1);
  endtask

  task automatic test_diag();
    fill_diag(8'd2, 8'd1);
    stream(100, 99);
    check_frame("diag_half2", 8'h20, 1'b0, EC + 1);
    fill_diag(8'd2, 8'd2);
    stream(100, 99);
    check_frame("diag_all2", 8'h00, 1'b0, EC + 1);
  endtask

  task automatic test_back_pressure();
    int lat;
    m_ready = 1'b0;
    fill_diag(8'd1, 8'd1);
    stream(100, 99);
    lat = 0;
    while (!m_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_det !== 8'h01 || m_err !== 1'b0 || s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable c=%0d: m_valid=%b m_det=%h m_err=%b s_ready=%b want 1 01 0 0",
                 c, m_valid, m_det, m_err, s_ready);
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
    stream(100, 99);
    check_frame("after_hold", 8'h01, 1'b0, EC + 1);
  endtask

  task automatic test_framing();
    fill_diag(8'd1, 8'd1);
    stream(43, 42);
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++; $display("FAIL early_last_ready: got %b want 0", s_ready);
    end
    check_frame("early_last", 8'h00, 1'b1, 0);
    fill_diag(8'd1, 8'd1);
    stream(100, -1);
    check_frame("missing_last", 8'h01, 1'b1, EC + 1);
    fill_diag(8'd2, 8'd1);
    stream(100, 99);
    check_frame("recover", 8'h20, 1'b0, EC + 1);
  endtask

  task automatic test_reset_midframe();
    int extra;
    fill_diag(8'd2, 8'd2);
    stream(57, -1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      n_err++; $display("FAIL midreset_during: m_valid=%b s_ready=%b want 0 0", m_valid, s_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_after: m_valid=%b want 0", m_valid);
    end
    fill_diag(8'd1, 8'd1);
    stream(100, 99);
    check_frame("post_reset", 8'h01, 1'b0, EC + 1);
    extra = 0;
    for (int c = 0; c < 150; c++) begin
      if (m_valid) extra++;
      @(negedge clk);
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++; $display("FAIL single_result: extra valid cycles %0d want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_swap();
    test_diag();
    test_back_pressure();
    test_framing();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
